uid_match_engine: RTL and testbench
===================================

// Module: uid_match_engine
// PURPOSE
// Parametrised user-ID matcher: collects DIGITS keypad digits, then scans the UID ROM for the entered ID.
// Sits between the button shaper/switches and the password checker. Raises matchID/isGuest/intID on a hit.
// Counts failed attempts; optional lockout after too many failures. log_out returns it to idle from any state.
// PARAMETERS
// DIGITS        4   digits per ID, entered MSB first
// DIGIT_W       4   bits per digit; ID width IDW = DIGITS*DIGIT_W
// ADDR_W        5   UID ROM address width
// USER_W        3   intID width; scan limit MAX_USERS = 2**USER_W entries
// ROM_LAT       2   cycles from addr_UID_ROM change to valid q_UID_ROM (>=1)
// MAX_FAILS     4   failed attempts before fail action (1..15)
// LOCKOUT_CYC   50000000   lockout length in clk cycles (used only with ID_LOCKOUT_EN)
// PORTS
// clk           in   1        system clock, 50 MHz
// rst           in   1        reset, asynchronous, active-low
// pwdigit       in   DIGIT_W  digit from toggle switches
// pwenter       in   1        single-cycle pulse from button shaper; latches pwdigit
// log_out       in   1        level; session end, forces IDLE
// q_UID_ROM     in   IDW      ROM data; all-ones = end-of-table sentinel
// addr_UID_ROM  out  ADDR_W   ROM address, zero-extended scan index
// matchID       out  1        high while a matched session is active
// isGuest       out  1        high with matchID when the match index is 0
// intID         out  USER_W   matched user index, valid while matchID=1
// fail_pulse    out  1        one-cycle pulse when one attempt fails
// locked        out  1        high during lockout (0 when ID_LOCKOUT_EN undefined)
// BEHAVIOUR
// - Reset (async, rst=0): all outputs 0, digit count 0, ID register 0, fail count 0, state IDLE.
// - States: IDLE -> ENTRY -> FETCH -> WAIT -> COMPARE -> {FETCH | MATCH | FAIL}; FAIL -> {ENTRY | LOCKED | IDLE}.
// - IDLE: clear ID register, digit count and scan index. Next cycle go to ENTRY. fail count is kept.
// - ENTRY: on pwenter, shift in pwdigit (ID <= {ID[IDW-DIGIT_W-1:0], pwdigit}) and increment the digit count.
//   The DIGITS-th pulse goes to FETCH. pwenter is ignored in every other state.
// - FETCH: addr_UID_ROM <= scan index; go to WAIT for ROM_LAT cycles. Then COMPARE samples q_UID_ROM.
// - COMPARE priority: sentinel -> FAIL; ID==q -> MATCH; index==MAX_USERS-1 -> FAIL; else index+1 -> FETCH.
// - Scan cost is ROM_LAT+2 cycles per entry. Entry k (0-based) matches with matchID high (k+1)*(ROM_LAT+2)+1 cycles after the last pwenter.
// - MATCH: matchID=1, intID=index, isGuest=(index==0), fail count cleared. Holds until log_out.
// - FAIL: fail_pulse=1 for one cycle and fail count+1 (saturating at 15).
//   Below MAX_FAILS: clear digits and index, go to ENTRY.
//   At MAX_FAILS: fail count cleared, go to LOCKED (macro defined) or IDLE (macro undefined).
// - log_out=1 in any state: next state IDLE and matchID/isGuest/intID cleared. log_out has priority over a same-cycle pwenter or match.
// - An ID value equal to all-ones can never match, because the sentinel is checked first.
// - Index arithmetic is USER_W bits. The index never wraps, because the scan stops at MAX_USERS-1.
// - The fail counter is 4 bits.
// - Illegal state encodings go to IDLE.
// CONFIGURATION
// - ID_LOCKOUT_EN defined: LOCKED state with locked=1.
//   A down-counter of width $clog2(LOCKOUT_CYC+1) is loaded with LOCKOUT_CYC and counts to 0, then goes to IDLE.
//   pwenter is ignored during lockout; log_out does not shorten it; reset does.
// - ID_LOCKOUT_EN undefined: no counter and no LOCKED state. locked is tied to 0. The MAX_FAILS-th failure goes to IDLE.
// TESTING (ROM: 0=16'h0000, 1=16'h1234, 2=16'hABCD, 3=16'hFFFF; defaults, ROM_LAT=2)
// - Enter 1,2,3,4 -> matchID=1, intID=1, isGuest=0, addr 0 then 1. Then log_out pulse -> all outputs 0 next cycle.
// - Enter 0,0,0,0 -> matchID=1, isGuest=1, intID=0, 5 cycles after the last pwenter.
// - Enter A,B,C,D -> matchID rises exactly 13 cycles after the last pwenter, intID=2.
// - Enter 5,5,5,5 -> scan reaches the sentinel at addr 3, one fail_pulse, back to ENTRY. Then 1,2,3,4 still matches.
// - 4 wrong IDs -> 4 fail_pulses. With ID_LOCKOUT_EN and LOCKOUT_CYC=20: locked=1 for 20 cycles, digits ignored, then IDLE.
// - Reset asserted mid-scan (state WAIT) -> outputs 0 immediately. After release a fresh entry of 1,2,3,4 matches normally.

Source files
------------

// File: rtl/uid_match_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uid_match_engine
// Description : Collects DIGITS keypad digits into a user ID, then scans the
//               UID ROM for it. A hit raises matchID/isGuest/intID until
//               log_out; a miss emits fail_pulse and counts failed attempts.
//               Optional feature macro: ID_LOCKOUT_EN (timed lockout after
//               MAX_FAILS failures; otherwise the engine returns to idle).
// Revision    : 1.0 - initial release
// ============================================================================
module uid_match_engine #(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 4,
  parameter int ADDR_W      = 5,
  parameter int USER_W      = 3,
  parameter int ROM_LAT     = 2,
  parameter int MAX_FAILS   = 4,
  parameter int LOCKOUT_CYC = 50000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIGIT_W-1:0]          pwdigit_i,
  input  logic                        pwenter_i,
  input  logic                        log_out_i,
  input  logic [DIGITS*DIGIT_W-1:0]   q_UID_ROM_i,
  output logic [ADDR_W-1:0]           addr_UID_ROM_o,
  output logic                        matchID_o,
  output logic                        isGuest_o,
  output logic [USER_W-1:0]           intID_o,
  output logic                        fail_pulse_o,
  output logic                        locked_o
);

  localparam int IDW = DIGITS * DIGIT_W;
  localparam int DCW = $clog2(DIGITS + 1);
  localparam int WCW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_FETCH   = 3'd2,
    S_WAIT    = 3'd3,
    S_COMPARE = 3'd4,
    S_MATCH   = 3'd5,
    S_FAIL    = 3'd6
`ifdef ID_LOCKOUT_EN
    ,
    S_LOCKED  = 3'd7
`endif
  } state_t;

  state_t              state_q;
  logic [IDW-1:0]      id_q;
  logic [DCW-1:0]      dcnt_q;
  logic [USER_W-1:0]   idx_q;
  logic [WCW-1:0]      wait_q;
  logic [3:0]          fail_cnt_q;
  logic [3:0]          fail_cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                match_q;
  logic                guest_q;
  logic [USER_W-1:0]   int_id_q;
  logic                fail_pulse_q;
  logic                logout_req;

  // Saturating increment of the failed-attempt counter
  assign fail_cnt_d = (fail_cnt_q == 4'd15) ? 4'd15 : fail_cnt_q + 4'd1;

`ifdef ID_LOCKOUT_EN
  localparam int LCW = $clog2(LOCKOUT_CYC + 1);
  logic [LCW-1:0] lock_cnt_q;
  logic           locked_q;

  // Lockout runs its full length: log_out cannot cut it short
  assign logout_req = log_out_i && (state_q != S_LOCKED);
  assign locked_o   = locked_q;
`else
  localparam int UNUSED_LOCKOUT_CYC = LOCKOUT_CYC;

  // Without lockout, log_out is honoured in every state
  assign logout_req = log_out_i;
  assign locked_o   = 1'b0;
`endif

  // Main controller: digit entry, ROM scan, match/fail handling, outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      id_q         <= '0;
      dcnt_q       <= '0;
      idx_q        <= '0;
      wait_q       <= '0;
      fail_cnt_q   <= 4'd0;
      addr_q       <= '0;
      match_q      <= 1'b0;
      guest_q      <= 1'b0;
      int_id_q     <= '0;
      fail_pulse_q <= 1'b0;
`ifdef ID_LOCKOUT_EN
      lock_cnt_q   <= '0;
      locked_q     <= 1'b0;
`endif
    end else begin
      fail_pulse_q <= 1'b0;
      if (logout_req) begin
        state_q  <= S_IDLE;
        match_q  <= 1'b0;
        guest_q  <= 1'b0;
        int_id_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            id_q     <= '0;
            dcnt_q   <= '0;
            idx_q    <= '0;
            match_q  <= 1'b0;
            guest_q  <= 1'b0;
            int_id_q <= '0;
            state_q  <= S_ENTRY;
          end
          S_ENTRY: begin
            if (pwenter_i) begin
              id_q   <= {id_q[IDW-DIGIT_W-1:0], pwdigit_i};
              dcnt_q <= dcnt_q + DCW'(1);
              if (dcnt_q == DCW'(DIGITS - 1)) begin
                state_q <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            addr_q  <= ADDR_W'(idx_q);
            wait_q  <= WCW'(ROM_LAT - 1);
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_q == '0) begin
              state_q <= S_COMPARE;
            end else begin
              wait_q <= wait_q - WCW'(1);
            end
          end
          S_COMPARE: begin
            // Sentinel first, so an all-ones ID can never match
            if (q_UID_ROM_i == {IDW{1'b1}}) begin
              state_q <= S_FAIL;
            end else if (q_UID_ROM_i == id_q) begin
              state_q <= S_MATCH;
            end else if (&idx_q) begin
              state_q <= S_FAIL;
            end else begin
              idx_q   <= idx_q + USER_W'(1);
              state_q <= S_FETCH;
            end
          end
          S_MATCH: begin
            match_q    <= 1'b1;
            int_id_q   <= idx_q;
            guest_q    <= (idx_q == '0);
            fail_cnt_q <= 4'd0;
          end
          S_FAIL: begin
            fail_pulse_q <= 1'b1;
            if (fail_cnt_d >= 4'(MAX_FAILS)) begin
              fail_cnt_q <= 4'd0;
`ifdef ID_LOCKOUT_EN
              lock_cnt_q <= LCW'(LOCKOUT_CYC);
              locked_q   <= 1'b1;
              state_q    <= S_LOCKED;
`else
              state_q    <= S_IDLE;
`endif
            end else begin
              fail_cnt_q <= fail_cnt_d;
              id_q       <= '0;
              dcnt_q     <= '0;
              idx_q      <= '0;
              state_q    <= S_ENTRY;
            end
          end
`ifdef ID_LOCKOUT_EN
          S_LOCKED: begin
            // locked stays high for exactly LOCKOUT_CYC cycles
            if (lock_cnt_q <= LCW'(1)) begin
              lock_cnt_q <= '0;
              locked_q   <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              lock_cnt_q <= lock_cnt_q - LCW'(1);
            end
          end
`endif
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign addr_UID_ROM_o = addr_q;
  assign matchID_o      = match_q;
  assign isGuest_o      = guest_q;
  assign intID_o        = int_id_q;
  assign fail_pulse_o   = fail_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_uid_match_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uid_match_engine
// Description : Directed self-checking bench for uid_match_engine with a
//               four-entry UID ROM model of two-cycle latency. Covers the
//               ID_LOCKOUT_EN lockout when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uid_match_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  pwdigit = 4'd0;
  logic        pwenter = 1'b0;
  logic        log_out = 1'b0;
  logic [15:0] q_rom;
  logic [4:0]  addr;
  logic        matchID;
  logic        isGuest;
  logic [2:0]  intID;
  logic        fail_pulse;
  logic        locked;

  int n_checks = 0;
  int n_fail   = 0;
  int mc;
  int fc;
  int n_lock;
  logic [4:0] a_c1;
  logic [4:0] a_c5;
  logic [4:0] a_last;

  uid_match_engine #(
    .DIGITS(4), .DIGIT_W(4), .ADDR_W(5), .USER_W(3),
    .ROM_LAT(2), .MAX_FAILS(4), .LOCKOUT_CYC(20)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pwdigit_i      (pwdigit),
    .pwenter_i      (pwenter),
    .log_out_i      (log_out),
    .q_UID_ROM_i    (q_rom),
    .addr_UID_ROM_o (addr),
    .matchID_o      (matchID),
    .isGuest_o      (isGuest),
    .intID_o        (intID),
    .fail_pulse_o   (fail_pulse),
    .locked_o       (locked)
  );

  always #5 clk = ~clk;

  // UID ROM contents; everything past entry 2 reads as the sentinel
  function automatic logic [15:0] rom_data(input logic [4:0] a);
    case (a)
      5'd0:    rom_data = 16'h0000;
      5'd1:    rom_data = 16'h1234;
      5'd2:    rom_data = 16'hABCD;
      default: rom_data = 16'hFFFF;
    endcase
  endfunction

  // Two-stage pipeline gives the ROM its two-cycle latency
  logic [15:0] rom_s1;
  logic [15:0] rom_s2;
  always @(posedge clk) begin
    rom_s1 <= rom_data(addr);
    rom_s2 <= rom_s1;
  end
  assign q_rom = rom_s2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    @(posedge clk); #1;
    pwdigit = d;
    pwenter = 1'b1;
    @(posedge clk); #1;
    pwenter = 1'b0;
  endtask

  task automatic enter_id(input logic [15:0] id);
    press(id[15:12]);
    press(id[11:8]);
    press(id[7:4]);
    press(id[3:0]);
  endtask

  // Counts cycles from the edge that took the last digit until matchID or
  // fail_pulse appears; -1 means it never did within the budget
  task automatic wait_result(output int match_cyc, output int fail_cyc);
    match_cyc = -1;
    fail_cyc  = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 1) a_c1 = addr;
      if (c == 5) a_c5 = addr;
      a_last = addr;
      if (matchID) begin
        match_cyc = c;
        break;
      end
      if (fail_pulse) begin
        fail_cyc = c;
        break;
      end
    end
  endtask

  task automatic do_logout();
    log_out = 1'b1;
    @(posedge clk); #1;
    log_out = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_match", 32'(matchID), 32'd0);
    check_eq("rst_guest", 32'(isGuest), 32'd0);
    check_eq("rst_intid", 32'(intID), 32'd0);
    check_eq("rst_fail",  32'(fail_pulse), 32'd0);
    check_eq("rst_lock",  32'(locked), 32'd0);
    check_eq("rst_addr",  32'(addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ID 1234 sits at entry 1
    enter_id(16'h1234);
    wait_result(mc, fc);
    check_eq("t1_cyc",   32'(mc), 32'd9);
    check_eq("t1_intid", 32'(intID), 32'd1);
    check_eq("t1_guest", 32'(isGuest), 32'd0);
    check_eq("t1_addr0", 32'(a_c1), 32'd0);
    check_eq("t1_addr1", 32'(a_c5), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t1_hold",  32'(matchID), 32'd1);
    do_logout();
    check_eq("t1_lo_match", 32'(matchID), 32'd0);
    check_eq("t1_lo_intid", 32'(intID), 32'd0);
    check_eq("t1_lo_guest", 32'(isGuest), 32'd0);

    // Guest ID at entry 0
    enter_id(16'h0000);
    wait_result(mc, fc);
    check_eq("t2_cyc",   32'(mc), 32'd5);
    check_eq("t2_guest", 32'(isGuest), 32'd1);
    check_eq("t2_intid", 32'(intID), 32'd0);
    do_logout();

    // Entry 2: (2+1)*4+1 = 13 cycles
    enter_id(16'hABCD);
    wait_result(mc, fc);
    check_eq("t3_cyc",   32'(mc), 32'd13);
    check_eq("t3_intid", 32'(intID), 32'd2);
    check_eq("t3_guest", 32'(isGuest), 32'd0);
    do_logout();

    // Unknown ID: scan runs into the sentinel at entry 3
    enter_id(16'h5555);
    wait_result(mc, fc);
    check_eq("t4_fail_cyc", 32'(fc), 32'd17);
    check_eq("t4_nomatch",  32'(mc), 32'hFFFF_FFFF);
    check_eq("t4_addr",     32'(a_last), 32'd3);
    @(posedge clk); #1;
    check_eq("t4_pulse_w",  32'(fail_pulse), 32'd0);
    enter_id(16'h1234);
    wait_result(mc, fc);
    check_eq("t4_retry_cyc", 32'(mc), 32'd9);
    check_eq("t4_retry_id",  32'(intID), 32'd1);
    do_logout();

    // Four consecutive failures (the match above cleared the count)
    for (int i = 0; i < 4; i++) begin
      enter_id(16'h5555);
      wait_result(mc, fc);
      check_eq($sformatf("t5_fail%0d", i), 32'(fc), 32'd17);
      if (i < 3) begin
        check_eq($sformatf("t5_unlocked%0d", i), 32'(locked), 32'd0);
      end
    end
`ifdef ID_LOCKOUT_EN
    check_eq("t5_locked", 32'(locked), 32'd1);
    // Hold pwenter with a digit and pulse log_out; neither may affect lockout
    n_lock  = 1;
    pwdigit = 4'd7;
    pwenter = 1'b1;
    for (int i = 0; i < 40; i++) begin
      log_out = (n_lock == 5);
      @(posedge clk); #1;
      if (locked) n_lock++;
      else break;
    end
    pwenter = 1'b0;
    log_out = 1'b0;
    check_eq("t5_lock_len", 32'(n_lock), 32'd20);
    check_eq("t5_lock_nomatch", 32'(matchID), 32'd0);
`else
    check_eq("t5_nolock", 32'(locked), 32'd0);
`endif
    enter_id(16'h1234);
    wait_result(mc, fc);
    check_eq("t5_after_cyc", 32'(mc), 32'd9);
    check_eq("t5_after_id",  32'(intID), 32'd1);
    do_logout();

    // Reset during the wait for entry 1
    enter_id(16'hABCD);
    repeat (6) @(posedge clk);
    #1;
    check_eq("t6_pre_addr", 32'(addr), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_addr",  32'(addr), 32'd0);
    check_eq("t6_rst_match", 32'(matchID), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    enter_id(16'h1234);
    wait_result(mc, fc);
    check_eq("t6_cyc",   32'(mc), 32'd9);
    check_eq("t6_intid", 32'(intID), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_m2",  32'(matchID), 32'd0);
    check_eq("t6_rst_id2", 32'(intID), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
